// File: rtl/row_span_sequencer_if.sv
// Descriptor load channel between the ray tracer (master) and the span
// sequencer (slave). One descriptor moves on each clk edge where
// load_valid and load_ready are both high.
interface row_span_sequencer_if #(
  parameter int FRAC = 10
);
  logic            load_valid;
  logic            load_ready;
  logic [1:0]      load_wall;
  logic            load_side;
  logic [10:0]     load_size;
  logic [5:0]      load_texu;
  logic [6+FRAC-1:0] load_vstart;
  logic [6+FRAC-1:0] load_vinc;

  modport master (
    output load_valid, load_wall, load_side, load_size,
           load_texu, load_vstart, load_vinc,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_wall, load_side, load_size,
           load_texu, load_vstart, load_vinc,
    output load_ready
  );
endinterface

// File: rtl/row_span_sequencer.sv
// Per-line wall-slice sequencer. Buffers one descriptor from the tracer in a
// shadow register, promotes it to the active set at line start, and steps
// the texture v accumulator across the wall span [span_lo, span_hi] as hpos
// advances. If no new descriptor arrives in time, the previous line repeats
// and underrun pulses.
module row_span_sequencer #(
  parameter int H_VIEW = 640,
  parameter int FRAC   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  row_span_sequencer_if.slave    ld,
  input  logic                   line_start,
  input  logic [9:0]             hpos,
  output logic [1:0]             wall,
  output logic                   side,
  output logic [10:0]            size,
  output logic [5:0]             texu,
  output logic [5:0]             texv,
  output logic                   row_valid,
  output logic                   underrun
);

  localparam int          ACC_W   = 6 + FRAC;
  localparam logic [10:0] CENTRE  = 11'(H_VIEW / 2);
  localparam logic [10:0] LAST_PX = 11'(H_VIEW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    SPAN = 2'd2,
    POST = 2'd3
  } state_t;

  // Left edge of the span; saturates at pixel 0 for slices wider than the view.
  function automatic logic [10:0] f_span_lo(input logic [10:0] s);
    return (s >= CENTRE) ? 11'd0 : CENTRE - s;
  endfunction

  // Right edge of the span; clamps to the last visible pixel.
  function automatic logic [10:0] f_span_hi(input logic [10:0] s);
    logic [11:0] sum;
    sum = {1'b0, CENTRE} + {1'b0, s};
    return (sum > {1'b0, LAST_PX}) ? LAST_PX : sum[10:0];
  endfunction

  // Shadow (pending) descriptor.
  logic             sh_full_q;
  logic [1:0]       sh_wall_q;
  logic             sh_side_q;
  logic [10:0]      sh_size_q;
  logic [5:0]       sh_texu_q;
  logic [ACC_W-1:0] sh_vstart_q;
  logic [ACC_W-1:0] sh_vinc_q;

  // Active descriptor driving the current line.
  logic [1:0]       act_wall_q;
  logic             act_side_q;
  logic [10:0]      act_size_q;
  logic [5:0]       act_texu_q;
  logic [ACC_W-1:0] act_vstart_q;
  logic [ACC_W-1:0] act_vinc_q;
  logic             row_valid_q;

  logic [ACC_W-1:0] acc_q;
  logic             underrun_q;
  state_t           state_q, state_d;

  logic             load_fire;
  logic             promote;
  logic             line_go;
  logic [10:0]      act_lo, act_hi, start_lo;
  logic [10:0]      hpos_x;
  logic             span_px;
  logic             acc_en;
  logic             acc_load;
  logic [ACC_W-1:0] acc_load_val;

  assign load_fire = ld.load_valid & ~sh_full_q;
  assign promote   = line_start & sh_full_q;
  // A line runs if there is a fresh descriptor or an old one to repeat.
  assign line_go   = line_start & (sh_full_q | row_valid_q);
  assign act_lo    = f_span_lo(act_size_q);
  assign act_hi    = f_span_hi(act_size_q);
  assign start_lo  = promote ? f_span_lo(sh_size_q) : act_lo;
  assign hpos_x    = {1'b0, hpos};

  // The PRE->SPAN transition cycle (hpos == span_lo) is itself a span pixel.
  assign span_px = (state_q == SPAN) || ((state_q == PRE) && (hpos_x == act_lo));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: line_start overrides whatever the previous line left.
  always_comb begin
    // NOTE: default first, so no path through the block leaves state_d
    // unassigned and a latch cannot be inferred.
    state_d = state_q;
    if (line_start) begin
      if (line_go) state_d = (start_lo == 11'd0) ? SPAN : PRE;
      else         state_d = IDLE;
    end else begin
      case (state_q)
        PRE:     if (hpos_x == act_lo) state_d = (hpos_x == act_hi) ? POST : SPAN;
        SPAN:    if (hpos_x == act_hi) state_d = POST;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: accumulator load at line start, step on span pixels before span_hi.
  always_comb begin
    acc_load     = line_go;
    acc_load_val = promote ? sh_vstart_q : act_vstart_q;
    acc_en       = 1'b0;
    if (span_px && (hpos_x >= act_lo) && (hpos_x < act_hi)) acc_en = 1'b1;
  end

  // Shadow register: fills on a handshake, empties on promotion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_full_q   <= 1'b0;
      sh_wall_q   <= '0;
      sh_side_q   <= 1'b0;
      sh_size_q   <= '0;
      sh_texu_q   <= '0;
      sh_vstart_q <= '0;
      sh_vinc_q   <= '0;
    end else if (load_fire) begin
      sh_full_q   <= 1'b1;
      sh_wall_q   <= ld.load_wall;
      sh_side_q   <= ld.load_side;
      sh_size_q   <= ld.load_size;
      sh_texu_q   <= ld.load_texu;
      sh_vstart_q <= ld.load_vstart;
      sh_vinc_q   <= ld.load_vinc;
    end else if (promote) begin
      sh_full_q   <= 1'b0;
    end
  end

  // Active set: changes only at line start when a fresh descriptor is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_wall_q   <= '0;
      act_side_q   <= 1'b0;
      act_size_q   <= '0;
      act_texu_q   <= '0;
      act_vstart_q <= '0;
      act_vinc_q   <= '0;
      row_valid_q  <= 1'b0;
    end else if (promote) begin
      act_wall_q   <= sh_wall_q;
      act_side_q   <= sh_side_q;
      act_size_q   <= sh_size_q;
      act_texu_q   <= sh_texu_q;
      act_vstart_q <= sh_vstart_q;
      act_vinc_q   <= sh_vinc_q;
      row_valid_q  <= 1'b1;
    end
  end

  // Texture v accumulator; wraps modulo 2^ACC_W so the texture tiles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         acc_q <= '0;
    else if (acc_load) acc_q <= acc_load_val;
    else if (acc_en)   acc_q <= acc_q + act_vinc_q;
  end

  // Underrun pulse: line start found nothing new in the shadow register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) underrun_q <= 1'b0;
    else       underrun_q <= line_start & ~sh_full_q;
  end

  assign ld.load_ready = ~sh_full_q;
  assign wall          = act_wall_q;
  assign side          = act_side_q;
  assign size          = act_size_q;
  assign texu          = act_texu_q;
  assign texv          = acc_q[ACC_W-1:FRAC];
  assign row_valid     = row_valid_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_row_span_sequencer.sv
// Self-checking bench for row_span_sequencer. Lines are 648 cycles: one
// line_start cycle, 640 visible pixels, 7 blanking cycles. The reference
// model tracks the shadow/active descriptors and computes texv directly as
// int(vstart + k*vinc) for the k-th span pixel.
module tb_row_span_sequencer;

  localparam int H_VIEW   = 640;
  localparam int FRAC     = 10;
  localparam int LINE_LEN = 648;

  typedef struct packed {
    logic [1:0]  wall;
    logic        side;
    logic [10:0] size;
    logic [5:0]  texu;
    logic [15:0] vstart;
    logic [15:0] vinc;
  } desc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  hpos = '0;
  logic [1:0]  wall;
  logic        side;
  logic [10:0] size;
  logic [5:0]  texu;
  logic [5:0]  texv;
  logic        row_valid;
  logic        underrun;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit    m_sh_full;
  desc_t m_sh;
  desc_t m_act;
  bit    m_act_valid;
  bit    m_underrun;

  row_span_sequencer_if #(.FRAC(FRAC)) lif ();

  row_span_sequencer #(.H_VIEW(H_VIEW), .FRAC(FRAC)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld         (lif.slave),
    .line_start (line_start),
    .hpos       (hpos),
    .wall       (wall),
    .side       (side),
    .size       (size),
    .texu       (texu),
    .texv       (texv),
    .row_valid  (row_valid),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (hpos %0d, t=%0t)", tag, got, exp, hpos, $time);
    end
  endtask

  // Expected texv for descriptor d at pixel h.
  function automatic logic [5:0] exp_texv(input desc_t d, input int h);
    int lo, hi, k, s;
    longint a;
    s  = int'(d.size);
    lo = (s >= H_VIEW / 2) ? 0 : H_VIEW / 2 - s;
    hi = (H_VIEW / 2 + s > H_VIEW - 1) ? H_VIEW - 1 : H_VIEW / 2 + s;
    if (h < lo)      k = 0;
    else if (h > hi) k = hi - lo;
    else             k = h - lo;
    a = (longint'(d.vstart) + longint'(k) * longint'(d.vinc)) % 64'd65536;
    return 6'(a >> FRAC);
  endfunction

  task automatic model_reset();
    m_sh_full   = 1'b0;
    m_sh        = '0;
    m_act       = '0;
    m_act_valid = 1'b0;
    m_underrun  = 1'b0;
  endtask

  // Advance the model across one clock edge given the inputs present there.
  task automatic model_step(input bit ls, input bit hs, input desc_t d);
    m_underrun = ls && !m_sh_full;
    if (ls && m_sh_full) begin
      m_act       = m_sh;
      m_act_valid = 1'b1;
      m_sh_full   = 1'b0;
    end
    if (hs) begin
      m_sh      = d;
      m_sh_full = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("row_valid",  32'(row_valid),      32'(m_act_valid));
    check("underrun",   32'(underrun),       32'(m_underrun));
    check("load_ready", 32'(lif.load_ready), 32'(!m_sh_full));
    check("wall",       32'(wall),           32'(m_act.wall));
    check("side",       32'(side),           32'(m_act.side));
    check("size",       32'(size),           32'(m_act.size));
    check("texu",       32'(texu),           32'(m_act.texu));
    check("texv",       32'(texv),           32'(exp_texv(m_act, int'(hpos))));
  endtask

  task automatic check_reset_values();
    check("rst_row_valid",  32'(row_valid),      32'd0);
    check("rst_underrun",   32'(underrun),       32'd0);
    check("rst_load_ready", 32'(lif.load_ready), 32'd1);
    check("rst_wall",       32'(wall),           32'd0);
    check("rst_side",       32'(side),           32'd0);
    check("rst_size",       32'(size),           32'd0);
    check("rst_texu",       32'(texu),           32'd0);
    check("rst_texv",       32'(texv),           32'd0);
  endtask

  // One video line. Optionally offers descriptor d from cycle load_at
  // (0 = the line_start cycle) until accepted, and optionally asserts
  // reset right after the cycle where hpos == reset_h.
  task automatic run_line(input bit do_load, input int load_at, input desc_t d, input int reset_h);
    bit pending;
    bit hs;
    int h;
    pending = 1'b0;
    for (int c = 0; c < LINE_LEN; c++) begin
      @(posedge clk);
      #1;
      h          = (c == 0) ? LINE_LEN - 1 : c - 1;
      hpos       = 10'(h);
      line_start = (c == 0);
      if (do_load && c == load_at) pending = 1'b1;
      lif.load_valid  = pending;
      lif.load_wall   = d.wall;
      lif.load_side   = d.side;
      lif.load_size   = d.size;
      lif.load_texu   = d.texu;
      lif.load_vstart = d.vstart;
      lif.load_vinc   = d.vinc;
      @(negedge clk);
      check_outputs();
      hs = pending && !m_sh_full;
      model_step(line_start, hs, d);
      if (hs) pending = 1'b0;
      if (reset_h >= 0 && c >= 1 && h == reset_h) begin
        #2;
        reset          = 1'b1;
        lif.load_valid = 1'b0;
        line_start     = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
    end
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    d.wall   = 2'($urandom);
    d.side   = 1'($urandom);
    d.size   = 11'($urandom_range(0, 1000));
    d.texu   = 6'($urandom);
    d.vstart = 16'($urandom);
    d.vinc   = 16'($urandom_range(0, 16'h1800));
    return d;
  endfunction

  desc_t d1, d2, d3, dz;

  initial begin
    lif.load_valid  = 1'b0;
    lif.load_wall   = '0;
    lif.load_side   = 1'b0;
    lif.load_size   = '0;
    lif.load_texu   = '0;
    lif.load_vstart = '0;
    lif.load_vinc   = '0;
    model_reset();

    d1 = '{wall: 2'd2, side: 1'b1, size: 11'd100, texu: 6'd5, vstart: 16'h0000, vinc: 16'h0200};
    d2 = '{wall: 2'd1, side: 1'b0, size: 11'd400, texu: 6'd33, vstart: 16'h2000, vinc: 16'h0400};
    d3 = '{wall: 2'd3, side: 1'b1, size: 11'd0,   texu: 6'd63, vstart: 16'h7C00, vinc: 16'h0800};
    dz = '0;

    #2 reset = 1'b1;
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle lines: underrun every line, nothing active.
    repeat (3) run_line(1'b0, 0, dz, -1);
    // Load d1 during an idle line; it becomes active next line.
    run_line(1'b1, 100, d1, -1);
    // d1 active (span 220..420); d2 loaded late in the line.
    run_line(1'b1, 500, d2, -1);
    // d2 active: span covers the whole line, no PRE cycles.
    run_line(1'b0, 0, dz, -1);
    // No load: d2 repeats with an underrun pulse.
    run_line(1'b0, 0, dz, -1);
    // Load coincides with line_start while the shadow is empty.
    run_line(1'b1, 0, d3, -1);
    // d3 (size 0) becomes active; single span pixel, no increment.
    run_line(1'b0, 0, dz, -1);

    // Randomized lines, including loads held off by a full shadow.
    for (int i = 0; i < 8; i++) begin
      run_line(($urandom_range(0, 3) != 0), $urandom_range(0, LINE_LEN - 1), rand_desc(), -1);
    end

    // Mid-span reset with a descriptor sitting in the shadow.
    run_line(1'b1, 30, d1, -1);
    run_line(1'b1, 50, d2, 300);
    // Shadow was discarded: underrun, row_valid stays 0.
    run_line(1'b0, 0, dz, -1);
    run_line(1'b1, 10, d1, -1);
    run_line(1'b0, 0, dz, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/row_span_sequencer.md
Name: row_span_sequencer

Overview:
- Per-line controller that feeds the row renderer during active video.
- Accepts one wall-slice descriptor per line from the ray tracer through a valid/ready handshake into a shadow register, and promotes it to the active set at line start.
- Sequences the texture 'v' coordinate across the wall span as hpos advances.
- Presents wall, side, size, texu and texv to the renderer and flags lines where the tracer missed its deadline.

Parameters:
- H_VIEW, 640, visible line width in pixels; the span centre is H_VIEW/2.
- FRAC, 10, number of fractional bits in the texv accumulator; the accumulator is 6+FRAC bits wide.

Ports:
- clk  in  1  system/pixel clock; hpos advances by one per clk.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  tracer has a descriptor.
- load_ready  out  1  shadow register is empty.
- load_wall  in  2  wall texture ID.
- load_side  in  1  light (1) or dark (0) side.
- load_size  in  11  half-height of the wall slice in pixels.
- load_texu  in  6  texture u coordinate.
- load_vstart  in  6+FRAC  accumulator value at the first span pixel.
- load_vinc  in  6+FRAC  texv increment per pixel, unsigned 6.FRAC.
- line_start  in  1  one-cycle pulse in the cycle before hpos==0 of each line.
- hpos  in  10  current horizontal position.
- wall  out  2  active wall ID.
- side  out  1  active side.
- size  out  11  active size.
- texu  out  6  active texu.
- texv  out  6  acc[6+FRAC-1:FRAC].
- row_valid  out  1  active set holds valid data.
- underrun  out  1  one-cycle pulse when line_start finds the shadow register empty.

Behaviour:
- Reset values: all outputs 0; load_ready=1; accumulator 0; state IDLE; shadow empty.
- Load handshake:
  - A transfer occurs on any clk edge with load_valid & load_ready.
  - The shadow register captures all load_* fields and load_ready drops next cycle.
  - load_ready rises again the cycle after the shadow is promoted.
- Line start (edge where line_start=1):
  - If the shadow is full: copy it to the active set, acc <= load_vstart of that entry, row_valid <= 1, shadow empty. Go to PRE, or to SPAN if span_lo==0.
  - If the shadow is empty and row_valid=1: keep the active set, acc <= active vstart (line repeats), underrun pulses 1, go to PRE or SPAN.
  - If the shadow is empty and row_valid=0: stay in IDLE; underrun still pulses.
  - If a handshake occurs on the same edge as line_start while the shadow is empty: the data lands in the shadow, is not used this line, and underrun pulses.
- Span bounds, combinational from the active size:
  - span_lo = (size >= H_VIEW/2) ? 0 : H_VIEW/2 - size.
  - span_hi = min(H_VIEW/2 + size, H_VIEW-1).
  - Width is 11 bits; no wrap.
- States:
  - IDLE: row_valid=0.
  - PRE -> SPAN when hpos==span_lo.
  - SPAN -> POST on the edge where hpos==span_hi.
  - POST holds until the next line_start.
- Accumulator:
  - On each edge in SPAN where hpos is in [span_lo, span_hi-1]: acc <= acc + vinc, modulo 2^(6+FRAC).
  - texv therefore equals int(vstart + k*vinc) at hpos = span_lo + k.
  - texv integer wrap 63 -> 0 is intended (texture tiling).
  - The accumulator is frozen in PRE and POST.
- size==0: span_lo = span_hi = H_VIEW/2. One pixel is in span and no increment occurs.
- Active outputs stay stable for the whole line and change only at line_start.
- Reset asserted mid-line: immediate return to the reset values. The shadow contents and the in-flight line are discarded.

Test Plan:
- Reset, then 3 idle lines with no loads -> row_valid=0, underrun pulses once per line_start, load_ready=1 throughout.
- Load {wall=2, side=1, size=100, texu=5, vstart=0, vinc=0x0200 (0.5)} then line_start -> row_valid=1, load_ready back to 1 one cycle later, texv=0 at hpos=220/221, 1 at 222, 63 at 346/347, 0 at 348 (wrap), frozen after hpos=420.
- size=400 (> 320), vstart=0x2000, vinc=0x0400 -> span_lo=0, span_hi=639, texv=8 at hpos=0 and 9 at hpos=1; no PRE cycles.
- No new load before the second line_start -> active fields unchanged, underrun=1 for exactly one cycle, texv sequence identical to the previous line.
- load_valid asserted on the same edge as line_start with the shadow empty -> underrun=1, the old line repeats, the new descriptor becomes active at the following line_start.
- Assert reset at hpos=300 mid-span -> outputs 0 asynchronously, load_ready=1, state IDLE; the next line_start with no load -> underrun pulse, row_valid stays 0.
